// File: rtl/lane_dispatch_buf_pkg.sv
// Shared constants for the 1-to-4 lane dispatch stage.
// Lane count, select width, per-lane FIFO geometry and stall counter width.
package lane_dispatch_buf_pkg;

    // Number of output lanes and the width of the lane select.
    localparam int LANES       = 4;
    localparam int SEL_W       = 2;

    // Per-lane FIFO geometry: two entries, one-bit pointers, count 0..2.
    localparam int DEPTH       = 2;
    localparam int PTR_W       = 1;
    localparam int CNT_W       = 2;

    // Width of the optional producer stall counter.
    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/lane_dispatch_buf_fifo2.sv
// lane_fifo2: one 2-entry FIFO lane with push/pop, head data, full and valid.
// The head is always read straight from storage, so there is no path from
// din to dout inside a cycle. Storage is cleared on reset.
module lane_fifo2
    import lane_dispatch_buf_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             valid
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Status and head word come from registered state only.
    always_comb begin
        full  = (count_q == CNT_W'(DEPTH));
        valid = (count_q != '0);
        dout  = mem_q[rd_ptr_q];
    end

    // Next-state: write at wr_ptr on push, advance rd_ptr on pop, track occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards all buffered words at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/lane_dispatch_buf.sv
// lane_dispatch_buf: registered 1-to-4 dispatch stage with a 2-entry FIFO per
// lane. Holds the lane select decode, the in_ready mux and, when the macro
// DISPATCH_STALL_CNT_EN is defined, a saturating producer stall counter.
module lane_dispatch_buf
    import lane_dispatch_buf_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic [WIDTH-1:0]       in_data,
    output logic [LANES-1:0]       out_valid,
    input  logic [LANES-1:0]       out_ready,
    output logic [LANES*WIDTH-1:0] out_data
`ifdef DISPATCH_STALL_CNT_EN
   ,output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    logic [LANES-1:0] full_lane;
    logic [LANES-1:0] push_lane;
    logic [LANES-1:0] pop_lane;
    logic             push;

    // A full lane still accepts a word when its head leaves in the same cycle;
    // in_ready deliberately ignores in_valid.
    always_comb begin
        in_ready = ~full_lane[in_sel] | out_ready[in_sel];
        push     = in_valid & in_ready;
        pop_lane = out_valid & out_ready;
    end

    // Route the accepted word to exactly one lane.
    always_comb begin
        push_lane = '0;
        for (int i = 0; i < LANES; i++) begin
            push_lane[i] = push && (in_sel == SEL_W'(i));
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_fifo2 #(
            .WIDTH (WIDTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push_lane[g]),
            .pop   (pop_lane[g]),
            .din   (in_data),
            .dout  (out_data[g*WIDTH +: WIDTH]),
            .full  (full_lane[g]),
            .valid (out_valid[g])
        );
    end

`ifdef DISPATCH_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (v == '1) ? v : v + STALL_CNT_W'(1);
    endfunction

    // Count cycles where the producer offers a word that cannot be taken.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && !in_ready) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
